// File: rtl/keypad_scan_encoder.sv
// Keypad front end: synchronise, priority-encode and debounce NUM_KEYS raw lines, plus a
// programmable tick muxed onto pgt. Optional auto-repeat is enabled by defining AUTO_REPEAT_EN.
module keypad_scan_encoder #(
  parameter int NUM_KEYS      = 10,
  parameter int CODE_W        = 4,
  parameter int DEB_CYCLES    = 50000,
  parameter int DIV_CYCLES    = 50_000_000,
  parameter int REPEAT_DELAY  = 25_000_000,
  parameter int REPEAT_PERIOD = 10_000_000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] keys,
  input  logic                en,
  output logic [CODE_W-1:0]   code,
  output logic                key_valid,
  output logic                load,
  output logic                tick,
  output logic                pgt
);

  localparam int CNT_W = $clog2(DEB_CYCLES);
  localparam int DIV_W = $clog2(DIV_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    PRESSED,
    RELEASE
  } state_t;

  if (NUM_KEYS < 2 || NUM_KEYS > 32 || CODE_W < $clog2(NUM_KEYS) || DEB_CYCLES < 2 ||
      DIV_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
    $error("keypad_scan_encoder: parameter out of range");
  end

  logic [NUM_KEYS-1:0] key_meta;
  logic [NUM_KEYS-1:0] key_sync;
  logic [NUM_KEYS-1:0] key_prev;
  logic                any;
  logic                changed;
  logic [CODE_W-1:0]   cur;

  state_t              state;
  state_t              state_next;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    cnt_next;
  logic [CODE_W-1:0]   cand;
  logic [CODE_W-1:0]   cand_next;
  logic [CODE_W-1:0]   code_next;
  logic                kv_next;

  logic [DIV_W-1:0]    div_cnt;

`ifdef AUTO_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  logic [RPT_W-1:0]    rpt_cnt;
  logic [RPT_W-1:0]    rpt_cnt_next;
  logic                rpt_seen;
  logic                rpt_seen_next;
  logic [RPT_W-1:0]    rpt_target;

  // First repeat waits the long delay, later ones the shorter period
  assign rpt_target = rpt_seen ? RPT_W'(REPEAT_PERIOD - 1) : RPT_W'(REPEAT_DELAY - 1);
`endif

  // key_prev lets RELEASE notice any movement on the lines and restart its count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_meta <= '0;
      key_sync <= '0;
      key_prev <= '0;
    end else begin
      key_meta <= keys;
      key_sync <= key_meta;
      key_prev <= key_sync;
    end
  end

  always_comb begin
    cur = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (key_sync[i]) cur = CODE_W'(i);
    end
  end

  assign any     = |key_sync;
  assign changed = (key_sync != key_prev);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      cand      <= '0;
      code      <= '0;
      key_valid <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      cand      <= cand_next;
      code      <= code_next;
      key_valid <= kv_next;
    end
  end

`ifdef AUTO_REPEAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpt_cnt  <= '0;
      rpt_seen <= 1'b0;
    end else begin
      rpt_cnt  <= rpt_cnt_next;
      rpt_seen <= rpt_seen_next;
    end
  end
`endif

  // Cooking mode overrides the keypad entirely; code keeps the last accepted key
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    cand_next  = cand;
    code_next  = code;
    kv_next    = 1'b0;
`ifdef AUTO_REPEAT_EN
    rpt_cnt_next  = '0;
    rpt_seen_next = 1'b0;
`endif
    if (en) begin
      state_next = IDLE;
      cnt_next   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (any) begin
            state_next = DEBOUNCE;
            cand_next  = cur;
            cnt_next   = '0;
          end
        end
        DEBOUNCE: begin
          if (!any || cur != cand) begin
            state_next = IDLE;
          end else if (cnt == CNT_W'(DEB_CYCLES - 1)) begin
            state_next = PRESSED;
            code_next  = cand;
            kv_next    = 1'b1;
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end
        PRESSED: begin
          if (!any || cur != cand) begin
            state_next = RELEASE;
            cnt_next   = '0;
          end else begin
`ifdef AUTO_REPEAT_EN
            if (rpt_cnt == rpt_target) begin
              kv_next       = 1'b1;
              rpt_cnt_next  = '0;
              rpt_seen_next = 1'b1;
            end else begin
              rpt_cnt_next  = rpt_cnt + 1'b1;
              rpt_seen_next = rpt_seen;
            end
`endif
          end
        end
        RELEASE: begin
          if (any && cur == cand) begin
            state_next = PRESSED;
          end else if (changed) begin
            cnt_next = '0;
          end else if (cnt == CNT_W'(DEB_CYCLES - 1)) begin
            state_next = IDLE;
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end
        default: begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

  // A key still counts as held while its release is being debounced
  assign load = (state == PRESSED) || (state == RELEASE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      tick    <= 1'b0;
    end else if (!en) begin
      div_cnt <= '0;
      tick    <= 1'b0;
    end else begin
      tick    <= (div_cnt == DIV_W'(DIV_CYCLES - 1));
      div_cnt <= (div_cnt == DIV_W'(DIV_CYCLES - 1)) ? '0 : div_cnt + 1'b1;
    end
  end

  assign pgt = en ? tick : key_valid;

endmodule
